// File: rtl/run_controller.sv
// run_controller: run-control and performance monitor gating the core.
// Define RUNCTL_WATCHDOG_EN to enable the enabled-cycle watchdog.
module run_controller #(
    parameter int CNT_W      = 32,
    parameter int NUM_CH     = 4,
    parameter int MAX_CYCLES = 750,
    parameter int HALT_HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    step_mode,
    input  logic                    step,
    input  logic                    halt,
    input  logic [NUM_CH-1:0]       evt,
    input  logic                    clear,
    output logic                    cpu_en,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt,
    output logic [2:0]              state,
    output logic                    done,
    output logic                    timeout
);

    localparam int HW = $clog2(HALT_HOLD + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_SWAIT = 3'd2;
    localparam logic [2:0] S_SEXEC = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_TOUT  = 3'd5;

    localparam logic [HW-1:0] HOLD = HW'(HALT_HOLD);

    logic [2:0]       st_q;
    logic [2:0]       st_d;
    logic [HW-1:0]    hcnt_q;
    logic [HW-1:0]    hcnt_inc;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ecnt_q [NUM_CH];
    logic             en;
    logic             halt_hit;
    logic             wd_hit;

    // Counting edges happen only while the core is enabled
    assign en       = (st_q == S_RUN) || (st_q == S_SEXEC);
    assign hcnt_inc = hcnt_q + 1'b1;
    assign halt_hit = en && halt && (hcnt_inc == HOLD);

`ifdef RUNCTL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
    assign wd_hit = en && (cyc_q == WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state: clear, then halt, then watchdog, then normal flow
    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = S_IDLE;
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    if (start) begin
                        st_d = step_mode ? S_SWAIT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt_hit) begin
                        st_d = S_HALT;
                    end else if (wd_hit) begin
                        st_d = S_TOUT;
                    end
                end
                S_SWAIT: begin
                    if (step) begin
                        st_d = S_SEXEC;
                    end
                end
                S_SEXEC: begin
                    if (halt_hit) begin
                        st_d = S_HALT;
                    end else if (wd_hit) begin
                        st_d = S_TOUT;
                    end else begin
                        st_d = S_SWAIT;
                    end
                end
                S_HALT:  st_d = S_HALT;
                S_TOUT:  st_d = S_TOUT;
                default: st_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        state  = st_q;
        cpu_en = en;
        done   = (st_q == S_HALT) || (st_q == S_TOUT);
`ifdef RUNCTL_WATCHDOG_EN
        timeout = (st_q == S_TOUT);
`else
        timeout = 1'b0;
`endif
    end

    // Saturating enabled-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else if (clear) begin
            cyc_q <= '0;
        end else if (en && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    // Saturating per-channel event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ecnt_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ecnt_q[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (evt[i] && (ecnt_q[i] != '1)) begin
                    ecnt_q[i] <= ecnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Halt filter: consecutive halted enabled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q <= '0;
        end else if (clear) begin
            hcnt_q <= '0;
        end else if (en) begin
            hcnt_q <= halt ? hcnt_inc : '0;
        end
    end

    assign cycle_cnt = cyc_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign evt_cnt[g*CNT_W +: CNT_W] = ecnt_q[g];
    end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: scoreboard bench for run_controller.
// Two instances (wide and narrow) share stimulus, each with its own model.
`timescale 1ns/1ps
module tb_run_controller;

    localparam int W0 = 32, C0 = 4, M0 = 750, H0 = 2;
    localparam int W1 = 4,  C1 = 2, M1 = 15,  H1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic step_mode = 1'b0;
    logic step = 1'b0;
    logic halt = 1'b0;
    logic clear = 1'b0;
    logic [3:0] evt = '0;

    logic          en0, dn0, to0;
    logic [W0-1:0] cyc0;
    logic [C0*W0-1:0] ev0;
    logic [2:0]    st0;
    logic          en1, dn1, to1;
    logic [W1-1:0] cyc1;
    logic [C1*W1-1:0] ev1;
    logic [2:0]    st1;

    always #5 clk = ~clk;

    run_controller #(.CNT_W(W0), .NUM_CH(C0), .MAX_CYCLES(M0), .HALT_HOLD(H0)) u0 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step(step), .halt(halt), .evt(evt), .clear(clear),
        .cpu_en(en0), .cycle_cnt(cyc0), .evt_cnt(ev0), .state(st0),
        .done(dn0), .timeout(to0)
    );

    run_controller #(.CNT_W(W1), .NUM_CH(C1), .MAX_CYCLES(M1), .HALT_HOLD(H1)) u1 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step(step), .halt(halt), .evt(evt[1:0]), .clear(clear),
        .cpu_en(en1), .cycle_cnt(cyc1), .evt_cnt(ev1), .state(st1),
        .done(dn1), .timeout(to1)
    );

    typedef struct packed {
        logic [2:0]       st;
        logic             en;
        logic             dn;
        logic             to;
        logic [63:0]      cyc;
        logic [3:0][63:0] ev;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int nchk;
    int nerr;

    // Reference model: phase per spec state names, plain integer counters
    int     mw[2], mch[2], mmax[2], mhold[2];
    int     ph[2];
    int     hs[2];
    longint mc[2];
    longint me[2][4];

    function automatic void mreset(int k);
        ph[k] = 0;
        hs[k] = 0;
        mc[k] = 0;
        for (int i = 0; i < 4; i++) me[k][i] = 0;
    endfunction

    function automatic void model(int k);
        longint sat;
        bit on;
        bit wd;
        sat = (longint'(1) << mw[k]) - 1;
        on = (ph[k] == 1) || (ph[k] == 3);
        wd = 1'b0;
        if (!reset) begin
            mreset(k);
        end else if (clear) begin
            mreset(k);
        end else if (on) begin
`ifdef RUNCTL_WATCHDOG_EN
            wd = (mc[k] == mmax[k] - 1);
`endif
            if (mc[k] < sat) mc[k]++;
            for (int i = 0; i < mch[k]; i++)
                if (evt[i] && me[k][i] < sat) me[k][i]++;
            hs[k] = halt ? hs[k] + 1 : 0;
            if (hs[k] >= mhold[k]) ph[k] = 4;
            else if (wd) ph[k] = 5;
            else if (ph[k] == 3) ph[k] = 2;
        end else if (ph[k] == 0 && start) begin
            ph[k] = step_mode ? 2 : 1;
        end else if (ph[k] == 2 && step) begin
            ph[k] = 3;
        end
    endfunction

    function automatic exp_t mexp(int k);
        exp_t e;
        e.st  = 3'(ph[k]);
        e.en  = (ph[k] == 1) || (ph[k] == 3);
        e.dn  = (ph[k] == 4) || (ph[k] == 5);
        e.to  = (ph[k] == 5);
        e.cyc = mc[k];
        for (int i = 0; i < 4; i++) e.ev[i] = me[k][i];
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic cmp(int k, exp_t e);
        logic [63:0] a_st, a_en, a_dn, a_to, a_cyc;
        logic [63:0] a_ev[4];
        if (k == 0) begin
            a_st = st0; a_en = en0; a_dn = dn0; a_to = to0; a_cyc = cyc0;
            for (int i = 0; i < C0; i++) a_ev[i] = ev0[i*W0 +: W0];
        end else begin
            a_st = st1; a_en = en1; a_dn = dn1; a_to = to1; a_cyc = cyc1;
            for (int i = 0; i < C1; i++) a_ev[i] = ev1[i*W1 +: W1];
        end
        chk($sformatf("u%0d.state", k), a_st, e.st);
        chk($sformatf("u%0d.cpu_en", k), a_en, e.en);
        chk($sformatf("u%0d.done", k), a_dn, e.dn);
        chk($sformatf("u%0d.timeout", k), a_to, e.to);
        chk($sformatf("u%0d.cycle_cnt", k), a_cyc, e.cyc);
        for (int i = 0; i < mch[k]; i++)
            chk($sformatf("u%0d.evt_cnt%0d", k, i), a_ev[i], e.ev[i]);
    endtask

    // Monitor: pop one expectation per instance and compare mid-cycle
    always @(negedge clk) begin
        if (q0.size() > 0) cmp(0, q0.pop_front());
        if (q1.size() > 0) cmp(1, q1.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        model(0);
        model(1);
        q0.push_back(mexp(0));
        q1.push_back(mexp(1));
        #1;
    endtask

    task automatic go(logic sm);
        start = 1'b1;
        step_mode = sm;
        tick();
        start = 1'b0;
    endtask

    task automatic doclr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Asynchronous reset between edges: outputs must drop immediately
    task automatic drop_reset();
        reset = 1'b0;
        #1;
        chk("rst.u0.cpu_en", en0, 0);
        chk("rst.u0.cycle_cnt", cyc0, 0);
        chk("rst.u0.evt_cnt", ev0 != '0, 0);
        chk("rst.u0.state", st0, 0);
        chk("rst.u0.done", dn0, 0);
        chk("rst.u1.cycle_cnt", cyc1, 0);
        chk("rst.u1.state", st1, 0);
        mreset(0);
        mreset(1);
        if (q0.size() > 0) q0[q0.size()-1] = mexp(0);
        if (q1.size() > 0) q1[q1.size()-1] = mexp(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        nchk = 0;
        nerr = 0;
        mw = '{W0, W1};
        mch = '{C0, C1};
        mmax = '{M0, M1};
        mhold = '{H0, H1};
        mreset(0);
        mreset(1);

        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Halt after two halted enabled cycles starting at cycle_cnt=10
        go(1'b0);
        for (int i = 0; i < 50 && mc[0] < 10; i++) begin
            evt = 4'($urandom);
            tick();
        end
        halt = 1'b1;
        tick();
        tick();
        halt = 1'b0;
        chk("halt.cycle_cnt", cyc0, 12);
        chk("halt.done", dn0, 1);
        chk("halt.cpu_en", en0, 0);
        chk("halt.timeout", to0, 0);
        chk("halt.state", st0, 4);
        chk("halt1.cycle_cnt", cyc1, 11);

        // Watchdog / free run with halt low
        doclr();
        go(1'b0);
        n = 0;
        for (int i = 0; i < 800; i++) begin
            if (en0) n++;
            evt = 4'($urandom);
            tick();
        end
`ifdef RUNCTL_WATCHDOG_EN
        chk("wd.en_cycles", n, 750);
        chk("wd.cycle_cnt", cyc0, 750);
        chk("wd.timeout", to0, 1);
        chk("wd.state", st0, 5);
`else
        chk("nowd.en_cycles", n, 800);
        chk("nowd.cycle_cnt", cyc0, 800);
        chk("nowd.timeout", to0, 0);
        chk("nowd.state", st0, 1);
`endif

        // Single step: isolated pulses, then held step
        doclr();
        go(1'b1);
        n = 0;
        repeat (3) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (en0) n++;
            repeat (3) begin
                tick();
                if (en0) n++;
            end
        end
        chk("step.pulses", n, 3);
        chk("step.cycle_cnt", cyc0, 3);
        step = 1'b1;
        repeat (10) tick();
        step = 1'b0;
        tick();
        chk("stephold.cycle_cnt", cyc0, 8);
        chk("stephold.state", st0, 2);

        // One-cycle halt glitch
        doclr();
        go(1'b0);
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (2) tick();
        chk("glitch.state", st0, 1);
        chk("glitch.filter", u0.hcnt_q, 0);
        chk("glitch1.state", st1, 4);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        chk("glitch2.state", st0, 1);

        // Saturation on the narrow instance
        doclr();
        go(1'b0);
        for (int i = 0; i < 20; i++) begin
            evt = 4'b0001 | ((i % 2 == 0) ? 4'b0010 : 4'b0000);
            tick();
        end
        evt = '0;
        chk("sat.evt0", ev1[3:0], 15);
`ifdef RUNCTL_WATCHDOG_EN
        chk("sat.evt1", ev1[7:4], 8);
`else
        chk("sat.evt1", ev1[7:4], 10);
`endif
        chk("sat.cycle_cnt", cyc1, 15);
        chk("sat.wide_evt1", ev0[63:32], 10);
        doclr();
        chk("clr.cycle_cnt", cyc1, 0);
        chk("clr.evt_cnt", ev1, 0);
        chk("clr.state", st1, 0);
        chk("clr.wide_state", st0, 0);

        // Reset mid-run at cycle_cnt=37, then restart
        go(1'b0);
        for (int i = 0; i < 100 && mc[0] < 37; i++) tick();
        chk("rst.pre_cycle_cnt", cyc0, 37);
        drop_reset();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        go(1'b0);
        chk("restart.cycle_cnt", cyc0, 0);
        chk("restart.cpu_en", en0, 1);
        tick();
        chk("restart.cycle_cnt1", cyc0, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom % 8) == 0;
            step_mode = 1'($urandom);
            step = 1'($urandom);
            halt = ($urandom % 6) == 0;
            evt = 4'($urandom);
            clear = ($urandom % 40) == 0;
            if ($urandom % 400 == 0) begin
                drop_reset();
                tick();
                reset = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        step = 1'b0;
        halt = 1'b0;
        clear = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk("sb.drain", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
